daisy_rr_arbiter: RTL and testbench
===================================

Name: daisy_rr_arbiter

Overview:
- Parametrised, registered N-requester arbiter; successor to the 4-bit combinational daisy-chain arbiter.
- Adds a clock, selectable fixed-priority or round-robin mode, and grant locking while the holder keeps requesting.
- Sits between N request sources and one shared resource; the consumer sees a one-hot grant plus an encoded index.

Parameters:
- N, 8, number of requesters (N >= 2).
- HOLD_W, 4, width of max_hold (used only with the optional feature).
- IDW, $clog2(N), width of gid (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- r  in  N  requests; r[i] is requester i, level-sensitive.
- mode  in  1  0 = fixed priority (lowest index wins, daisy-chain order); 1 = round-robin.
- max_hold  in  HOLD_W  grant-cycle limit under contention; ignored unless GRANT_TIMEOUT_EN is defined.
- g  out  N  registered one-hot grant; all-zero when idle.
- gv  out  1  1 when any g bit is set.
- gid  out  IDW  index of the granted requester; 0 when idle.

Behaviour:
- Reset (async, rst_n=0): g=0, gv=0, gid=0, state=IDLE, rr pointer ptr=0, hold counter=0. Outputs clear immediately, not at the next edge.
- Latency: r is sampled at edge k and g reflects the decision after edge k. No combinational path from r to g.
- State IDLE: if r==0, stay in IDLE. Otherwise arbitrate, load g/gid, set gv=1 and go to GRANT.
- State GRANT:
  - If r[gid]==1, hold the grant (lock). No preemption by higher-priority requests or by a mode change.
  - If r[gid]==0, arbitrate over the current r at the same edge. Any winner is granted with zero idle cycles. If no requester remains, go to IDLE (g=0 after that edge).
- Arbitration:
  - mode=0: the lowest set index wins.
  - mode=1: search starts at ptr and wraps modulo N; the first set bit wins.
- ptr update: on every new grant in either mode, ptr <= (winner+1) mod N. When N is not a power of two, a winner of N-1 wraps ptr to 0.
- mode is sampled only at arbitration edges. A change while a grant is held takes effect at the next decision.
- Invariants (bench assertions): g is always one-hot or zero; gv == |g; gid matches g.
- Reset asserted mid-grant drops the grant immediately. After release, arbitration restarts with ptr=0.

Optional Feature:
- Macro: GRANT_TIMEOUT_EN.
- Defined:
  - A hold counter resets to 1 on each new grant and increments (saturating) each edge the grant is held.
  - Preemption fires when max_hold != 0, the counter equals max_hold, r[gid] is still 1, and another r bit is set. The grant then moves to a new winner chosen with the holder's bit masked out, in either mode, and ptr updates as normal.
  - Preemption never produces an idle gap; the holder gets exactly max_hold consecutive grant cycles.
  - With no other requester, the holder keeps the grant and the counter saturates.
  - max_hold=0 disables preemption.
- Not defined: no counter is instantiated, max_hold is unconnected internally, and the pure lock behaviour above applies.

Test Plan (N=4):
- Reset: hold g[2]=1, then pull rst_n=0 between edges → g=0, gv=0, gid=0 before the next edge. Release with r=4'b1111, mode=0 → after the first edge g[0]=1, gid=0.
- Fixed lock: mode=0, assert r[2] → g[2]=1. Assert r[0] while r[2] is held → g[2] stays 1 for 5 cycles. Drop r[2] → g[0]=1 on the very next edge with gv never 0.
- Round-robin rotation: mode=1, all r=1, and each holder drops its r for one cycle on the edge after its grant → grant order 0,1,2,3,0 with no idle cycles between.
- Mode switch: mode=0 with g[3]=1 and r[0],r[3] set. Switch to mode=1 → g[3] is held. Drop r[3] → next winner is index 0, since ptr has wrapped from 3.
- Timeout (GRANT_TIMEOUT_EN): mode=1, max_hold=3, r[0] and r[1] held at 1 → g[0] for 3 cycles, then g[1] for 3 cycles, repeating. With max_hold=0 → g[0] is held indefinitely.
- Timeout, single requester: only r[3]=1, max_hold=2 → g[3] held for 20 cycles, gv stays 1.

Source files
------------

// File: rtl/daisy_rr_arbiter.sv
// Registered N-requester arbiter: fixed-priority or round-robin, with grant locking.
// Optional grant timeout under contention is enabled by defining GRANT_TIMEOUT_EN.
module daisy_rr_arbiter #(
    parameter int N      = 8,
    parameter int HOLD_W = 4,
    localparam int IDW   = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      r,
    input  logic              mode,
    input  logic [HOLD_W-1:0] max_hold,
    output logic [N-1:0]      g,
    output logic              gv,
    output logic [IDW-1:0]    gid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         r_state, w_state_n;
    logic [N-1:0]   r_g, w_g_n;
    logic [IDW-1:0] r_gid, w_gid_n;
    logic [IDW-1:0] r_ptr, w_ptr_n;

    logic           w_hold;
    logic           w_preempt;
    logic           w_decide;
    logic [N-1:0]   w_mask;
    logic [IDW-1:0] w_start;
    logic [IDW-1:0] w_win;
    logic           w_found;

`ifdef GRANT_TIMEOUT_EN
    logic [HOLD_W-1:0] r_cnt, w_cnt_n;
`else
    logic w_unused_hold;
    assign w_unused_hold = ^max_hold;
`endif

    assign w_hold = (r_state == GRANT) && r[r_gid];

`ifdef GRANT_TIMEOUT_EN
    assign w_preempt = w_hold && (max_hold != '0) && (r_cnt == max_hold)
                       && ((r & ~r_g) != '0);
`else
    assign w_preempt = 1'b0;
`endif

    // On preemption the current holder is masked out so someone else must win.
    assign w_mask   = w_preempt ? (r & ~r_g) : r;
    assign w_start  = mode ? r_ptr : '0;
    assign w_decide = (r_state == IDLE) || !w_hold || w_preempt;

    always_comb begin
        int unsigned v_idx;
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            v_idx = 32'(w_start) + k;
            if (v_idx >= N) v_idx = v_idx - N;
            if (!w_found && w_mask[v_idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(v_idx);
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_g_n     = r_g;
        w_gid_n   = r_gid;
        w_ptr_n   = r_ptr;
`ifdef GRANT_TIMEOUT_EN
        w_cnt_n   = r_cnt;
`endif
        if (w_decide) begin
            if (w_found) begin
                w_state_n      = GRANT;
                w_g_n          = '0;
                w_g_n[w_win]   = 1'b1;
                w_gid_n        = w_win;
                w_ptr_n        = (w_win == IDW'(N - 1)) ? '0 : w_win + 1'b1;
`ifdef GRANT_TIMEOUT_EN
                w_cnt_n        = HOLD_W'(1);
`endif
            end else begin
                w_state_n = IDLE;
                w_g_n     = '0;
                w_gid_n   = '0;
`ifdef GRANT_TIMEOUT_EN
                w_cnt_n   = '0;
`endif
            end
        end else begin
`ifdef GRANT_TIMEOUT_EN
            if (r_cnt != '1) w_cnt_n = r_cnt + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_g     <= '0;
            r_gid   <= '0;
            r_ptr   <= '0;
`ifdef GRANT_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_n;
            r_g     <= w_g_n;
            r_gid   <= w_gid_n;
            r_ptr   <= w_ptr_n;
`ifdef GRANT_TIMEOUT_EN
            r_cnt   <= w_cnt_n;
`endif
        end
    end

    assign g   = r_g;
    assign gv  = |r_g;
    assign gid = r_gid;

endmodule

// File: tb/tb_daisy_rr_arbiter.sv
// Directed, table-driven bench for daisy_rr_arbiter at N=4.
// Timeout sequences are compiled in only when GRANT_TIMEOUT_EN is defined.
module tb_daisy_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] r = '0;
    logic       mode = 1'b0;
    logic [3:0] max_hold = '0;
    logic [3:0] g;
    logic       gv;
    logic [1:0] gid;

    int n_tests = 0;
    int n_fail  = 0;

    daisy_rr_arbiter #(.N(4), .HOLD_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .r(r), .mode(mode), .max_hold(max_hold),
        .g(g), .gv(gv), .gid(gid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] r;
        logic       m;
        logic [3:0] eg;
        logic [1:0] eid;
        string      name;
    } vec_t;

    vec_t tv[$];

    function automatic void add(logic rs, logic [3:0] rr, logic m,
                                logic [3:0] eg, logic [1:0] eid, string nm);
        vec_t v;
        v.rst = rs; v.r = rr; v.m = m; v.eg = eg; v.eid = eid; v.name = nm;
        tv.push_back(v);
    endfunction

    task automatic check(string nm, logic [3:0] eg, logic [1:0] eid);
        logic egv;
        egv = (eg != 4'b0);
        n_tests++;
        if (g !== eg || gid !== eid || gv !== egv) begin
            n_fail++;
            $display("FAIL %s: got g=%b gv=%b gid=%0d, expected g=%b gv=%b gid=%0d",
                     nm, g, gv, gid, eg, egv, eid);
        end
        n_tests++;
        if (!$onehot0(g) || gv !== (|g) || (g != 4'b0 && g[gid] !== 1'b1)
            || (g == 4'b0 && gid !== 2'd0)) begin
            n_fail++;
            $display("FAIL %s_inv: got g=%b gv=%b gid=%0d, expected onehot0 g consistent with gv/gid",
                     nm, g, gv, gid);
        end
    endtask

    task automatic step(logic [3:0] rr, logic m);
        @(negedge clk);
        r = rr;
        mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // fixed-priority lock
        add(1, 4'b0100, 0, 4'b0100, 2'd2, "fix_first");
        for (int i = 0; i < 5; i++) add(0, 4'b0101, 0, 4'b0100, 2'd2, "fix_lock");
        add(0, 4'b0001, 0, 4'b0001, 2'd0, "fix_handoff");
        add(0, 4'b0000, 0, 4'b0000, 2'd0, "fix_idle");
        // round-robin rotation from ptr=0
        add(1, 4'b1111, 1, 4'b0001, 2'd0, "rr_0");
        add(0, 4'b1110, 1, 4'b0010, 2'd1, "rr_1");
        add(0, 4'b1101, 1, 4'b0100, 2'd2, "rr_2");
        add(0, 4'b1011, 1, 4'b1000, 2'd3, "rr_3");
        add(0, 4'b0111, 1, 4'b0001, 2'd0, "rr_0b");
        add(0, 4'b1111, 1, 4'b0001, 2'd0, "rr_lock");
        add(0, 4'b0000, 1, 4'b0000, 2'd0, "rr_idle");
        // mode switch while held (ptr=1 here)
        add(0, 4'b1000, 0, 4'b1000, 2'd3, "ms_g3");
        add(0, 4'b1001, 0, 4'b1000, 2'd3, "ms_hold_m0");
        add(0, 4'b1001, 1, 4'b1000, 2'd3, "ms_hold_m1");
        add(0, 4'b0001, 1, 4'b0001, 2'd0, "ms_wrap_win0");
        add(0, 4'b0000, 1, 4'b0000, 2'd0, "ms_idle");
        add(0, 4'b0101, 1, 4'b0100, 2'd2, "rr_ptr1_skip0");
        add(0, 4'b1001, 1, 4'b1000, 2'd3, "rr_ptr3");
        add(0, 4'b0011, 1, 4'b0001, 2'd0, "rr_ptr_wrap");
        add(0, 4'b0011, 0, 4'b0001, 2'd0, "rr_hold_m0");

        // power-on reset state
        rst_n = 1'b0;
        #12;
        check("reset_state", 4'b0000, 2'd0);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            if (tv[i].rst) pulse_reset();
            step(tv[i].r, tv[i].m);
            check(tv[i].name, tv[i].eg, tv[i].eid);
        end

        // async reset mid-grant, release with mode=0
        pulse_reset();
        step(4'b0100, 1);
        check("pre_rst_g2", 4'b0100, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_clear", 4'b0000, 2'd0);
        @(negedge clk);
        r = 4'b1111;
        mode = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_fixed", 4'b0001, 2'd0);

        // ptr must restart at 0 after reset (was 3 before it)
        step(4'b0000, 1);
        step(4'b0100, 1);
        check("pre_rst2_g2", 4'b0100, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst2_clear", 4'b0000, 2'd0);
        @(negedge clk);
        r = 4'b1111;
        mode = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ptr0", 4'b0001, 2'd0);

`ifdef GRANT_TIMEOUT_EN
        // alternating 3-cycle slots between requesters 0 and 1
        pulse_reset();
        max_hold = 4'd3;
        for (int c = 0; c < 12; c++) begin
            step(4'b0011, 1);
            if (((c / 3) % 2) == 0) check("to_alt_g0", 4'b0001, 2'd0);
            else                    check("to_alt_g1", 4'b0010, 2'd1);
        end
        pulse_reset();
        max_hold = 4'd0;
        for (int c = 0; c < 10; c++) begin
            step(4'b0011, 1);
            check("to_disabled", 4'b0001, 2'd0);
        end
        pulse_reset();
        max_hold = 4'd2;
        for (int c = 0; c < 20; c++) begin
            step(4'b1000, 1);
            check("to_single", 4'b1000, 2'd3);
        end
        max_hold = 4'd0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
